// File: rtl/kdtree_stream_loader_if.sv
// Stream-side and storage-side signals of the kd-tree load sequencer.
// The master modport is the loader; the slave modport is its environment.
interface kdtree_stream_loader_if #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494
);
  localparam int NUM_NODES   = NUM_LEAVES - 1;
  localparam int LEAF_ADDRW  = $clog2(NUM_LEAVES);
  localparam int NODE_ADDRW  = $clog2(NUM_NODES);
  localparam int QUERY_ADDRW = $clog2(NUM_QUERYS);
  localparam int SLOTW       = $clog2(LEAF_SIZE);
  localparam int PATCHW      = PATCH_SIZE * DATA_WIDTH;

  logic                   load_kdtree;
  logic                   load_query;
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   in_ready;
  logic                   node_wen;
  logic [NODE_ADDRW-1:0]  node_waddr;
  logic [DATA_WIDTH-1:0]  node_dim;
  logic [DATA_WIDTH-1:0]  node_median;
  logic                   leaf_wen;
  logic [LEAF_ADDRW-1:0]  leaf_waddr;
  logic [SLOTW-1:0]       leaf_slot;
  logic [PATCHW-1:0]      leaf_wdata;
  logic [IDX_WIDTH-1:0]   leaf_widx;
  logic                   query_wen;
  logic [QUERY_ADDRW-1:0] query_waddr;
  logic [PATCHW-1:0]      query_wdata;
  logic                   busy;
  logic                   tree_loaded;
  logic                   query_loaded;
  logic                   cmd_err;

  modport master (
    input  load_kdtree, load_query, in_valid, in_data,
    output in_ready,
    output node_wen, node_waddr, node_dim, node_median,
    output leaf_wen, leaf_waddr, leaf_slot, leaf_wdata, leaf_widx,
    output query_wen, query_waddr, query_wdata,
    output busy, tree_loaded, query_loaded, cmd_err
  );

  modport slave (
    output load_kdtree, load_query, in_valid, in_data,
    input  in_ready,
    input  node_wen, node_waddr, node_dim, node_median,
    input  leaf_wen, leaf_waddr, leaf_slot, leaf_wdata, leaf_widx,
    input  query_wen, query_waddr, query_wdata,
    input  busy, tree_loaded, query_loaded, cmd_err
  );
endinterface

// File: rtl/kdtree_stream_loader.sv
// Load sequencer: turns the single-word input stream into node, leaf-patch and
// query-patch write transactions (full load or queries-only reload).
module kdtree_stream_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494
) (
  input logic                  clk,
  input logic                  rst,
  kdtree_stream_loader_if.master io
);
  localparam int NUM_NODES   = NUM_LEAVES - 1;
  localparam int LEAF_ADDRW  = $clog2(NUM_LEAVES);
  localparam int NODE_ADDRW  = $clog2(NUM_NODES);
  localparam int QUERY_ADDRW = $clog2(NUM_QUERYS);
  localparam int SLOTW       = $clog2(LEAF_SIZE);
  localparam int ELEMW       = $clog2(PATCH_SIZE + 1);
  localparam int ITEMW_NL    = (NODE_ADDRW > LEAF_ADDRW) ? NODE_ADDRW : LEAF_ADDRW;
  localparam int ITEMW       = (ITEMW_NL > QUERY_ADDRW) ? ITEMW_NL : QUERY_ADDRW;
  localparam int PATCHW      = PATCH_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NODES,
    S_LEAVES,
    S_QUERIES
  } state_t;

  state_t                 r_state;
  logic [ELEMW-1:0]       r_elem;
  logic [SLOTW-1:0]       r_slot;
  logic [ITEMW-1:0]       r_item;
  logic [PATCHW-1:0]      r_shift;

  logic                   r_node_wen;
  logic [NODE_ADDRW-1:0]  r_node_waddr;
  logic [DATA_WIDTH-1:0]  r_node_dim;
  logic [DATA_WIDTH-1:0]  r_node_median;
  logic                   r_leaf_wen;
  logic [LEAF_ADDRW-1:0]  r_leaf_waddr;
  logic [SLOTW-1:0]       r_leaf_slot;
  logic [PATCHW-1:0]      r_leaf_wdata;
  logic [IDX_WIDTH-1:0]   r_leaf_widx;
  logic                   r_query_wen;
  logic [QUERY_ADDRW-1:0] r_query_waddr;
  logic [PATCHW-1:0]      r_query_wdata;
  logic                   r_tree_loaded;
  logic                   r_query_loaded;
  logic                   r_cmd_err;

  logic w_busy;
  logic w_accept;
  logic w_node_last;
  logic w_leaf_last;
  logic w_slot_last;
  logic w_query_last;

  assign w_busy       = (r_state != S_IDLE);
  assign w_accept     = w_busy && io.in_valid;
  assign w_node_last  = (r_item == ITEMW'(NUM_NODES - 1));
  assign w_slot_last  = (r_slot == SLOTW'(LEAF_SIZE - 1));
  assign w_leaf_last  = (r_item == ITEMW'(NUM_LEAVES - 1)) && w_slot_last;
  assign w_query_last = (r_item == ITEMW'(NUM_QUERYS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_elem         <= '0;
      r_slot         <= '0;
      r_item         <= '0;
      r_shift        <= '0;
      r_node_wen     <= 1'b0;
      r_node_waddr   <= '0;
      r_node_dim     <= '0;
      r_node_median  <= '0;
      r_leaf_wen     <= 1'b0;
      r_leaf_waddr   <= '0;
      r_leaf_slot    <= '0;
      r_leaf_wdata   <= '0;
      r_leaf_widx    <= '0;
      r_query_wen    <= 1'b0;
      r_query_waddr  <= '0;
      r_query_wdata  <= '0;
      r_tree_loaded  <= 1'b0;
      r_query_loaded <= 1'b0;
      r_cmd_err      <= 1'b0;
    end else begin
      r_node_wen  <= 1'b0;
      r_leaf_wen  <= 1'b0;
      r_query_wen <= 1'b0;

      if (r_state == S_IDLE) begin
        if (io.load_kdtree) begin
          r_state        <= S_NODES;
          r_tree_loaded  <= 1'b0;
          r_query_loaded <= 1'b0;
          r_elem         <= '0;
          r_slot         <= '0;
          r_item         <= '0;
        end else if (io.load_query) begin
          if (r_tree_loaded) begin
            r_state        <= S_QUERIES;
            r_query_loaded <= 1'b0;
            r_elem         <= '0;
            r_slot         <= '0;
            r_item         <= '0;
          end else begin
            r_cmd_err <= 1'b1;
          end
        end
      end else if (io.load_kdtree || io.load_query) begin
        r_cmd_err <= 1'b1;
      end

      // Words enter at the top so element 0 lands in the LSBs once a patch is in;
      // during NODES the top slot doubles as the holding register for dim.
      if (w_accept) begin
        r_shift <= {io.in_data, r_shift[PATCHW-1:DATA_WIDTH]};
        case (r_state)
          S_NODES: begin
            if (r_elem == '0) begin
              r_elem <= ELEMW'(1);
            end else begin
              r_elem        <= '0;
              r_node_wen    <= 1'b1;
              r_node_waddr  <= r_item[NODE_ADDRW-1:0];
              r_node_dim    <= r_shift[PATCHW-1 -: DATA_WIDTH];
              r_node_median <= io.in_data;
              if (w_node_last) begin
                r_state <= S_LEAVES;
                r_item  <= '0;
                r_slot  <= '0;
              end else begin
                r_item <= r_item + 1'b1;
              end
            end
          end
          S_LEAVES: begin
            if (r_elem != ELEMW'(PATCH_SIZE)) begin
              r_elem <= r_elem + 1'b1;
            end else begin
              r_elem       <= '0;
              r_leaf_wen   <= 1'b1;
              r_leaf_waddr <= r_item[LEAF_ADDRW-1:0];
              r_leaf_slot  <= r_slot;
              r_leaf_wdata <= r_shift;
              r_leaf_widx  <= io.in_data[IDX_WIDTH-1:0];
              if (w_leaf_last) begin
                r_state       <= S_QUERIES;
                r_tree_loaded <= 1'b1;
                r_item        <= '0;
                r_slot        <= '0;
              end else if (w_slot_last) begin
                r_slot <= '0;
                r_item <= r_item + 1'b1;
              end else begin
                r_slot <= r_slot + 1'b1;
              end
            end
          end
          S_QUERIES: begin
            if (r_elem != ELEMW'(PATCH_SIZE - 1)) begin
              r_elem <= r_elem + 1'b1;
            end else begin
              r_elem        <= '0;
              r_query_wen   <= 1'b1;
              r_query_waddr <= r_item[QUERY_ADDRW-1:0];
              r_query_wdata <= {io.in_data, r_shift[PATCHW-1:DATA_WIDTH]};
              if (w_query_last) begin
                r_state        <= S_IDLE;
                r_query_loaded <= 1'b1;
                r_item         <= '0;
              end else begin
                r_item <= r_item + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io.in_ready     = w_accept;
  assign io.busy         = w_busy;
  assign io.node_wen     = r_node_wen;
  assign io.node_waddr   = r_node_waddr;
  assign io.node_dim     = r_node_dim;
  assign io.node_median  = r_node_median;
  assign io.leaf_wen     = r_leaf_wen;
  assign io.leaf_waddr   = r_leaf_waddr;
  assign io.leaf_slot    = r_leaf_slot;
  assign io.leaf_wdata   = r_leaf_wdata;
  assign io.leaf_widx    = r_leaf_widx;
  assign io.query_wen    = r_query_wen;
  assign io.query_waddr  = r_query_waddr;
  assign io.query_wdata  = r_query_wdata;
  assign io.tree_loaded  = r_tree_loaded;
  assign io.query_loaded = r_query_loaded;
  assign io.cmd_err      = r_cmd_err;
endmodule

// File: doc/kdtree_stream_loader.md
# kdtree_stream_loader

Parametrised load sequencer that turns the single-word input stream (after the IO-clock FIFO) into wide write transactions for the internal-node memory, the leaf patch memory and the query patch memory. It generalises the fixed nodes→leaves→queries load order with a queries-only reload mode, backpressure, and command error flags. It sits between the input FIFO dequeue side and the storage macros inside the ANN top level, and runs on the core clock.

## Interface
- DATA_WIDTH, 11, width of one stream word / one patch element
- IDX_WIDTH, 9, patch index width (original-image position)
- PATCH_SIZE, 5, elements per patch
- LEAF_SIZE, 8, patches per leaf
- NUM_LEAVES, 64, leaves in the kd tree; NUM_NODES = NUM_LEAVES-1
- NUM_QUERYS, 494, query patches per frame
- LEAF_ADDRW, $clog2(NUM_LEAVES); NODE_ADDRW, $clog2(NUM_NODES); QUERY_ADDRW, $clog2(NUM_QUERYS)

Ports:
- clk  in  1  core clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- load_kdtree  in  1  one-cycle command: full load (nodes, leaves, queries)
- load_query  in  1  one-cycle command: queries-only reload
- in_valid  in  1  stream word present (FIFO not empty)
- in_data  in  DATA_WIDTH  stream word
- in_ready  out  1  word consumed this cycle (drives FIFO deq)
- node_wen  out  1  node write strobe
- node_waddr  out  NODE_ADDRW  node index
- node_dim  out  DATA_WIDTH  split dimension (first word of pair)
- node_median  out  DATA_WIDTH  split value (second word)
- leaf_wen  out  1  leaf patch write strobe
- leaf_waddr  out  LEAF_ADDRW  leaf number
- leaf_slot  out  $clog2(LEAF_SIZE)  patch slot in leaf
- leaf_wdata  out  PATCH_SIZE*DATA_WIDTH  element 0 in LSBs
- leaf_widx  out  IDX_WIDTH  patch index (low IDX_WIDTH bits of 6th word)
- query_wen  out  1  query write strobe
- query_waddr  out  QUERY_ADDRW  query number
- query_wdata  out  PATCH_SIZE*DATA_WIDTH  element 0 in LSBs
- busy  out  1  state ≠ IDLE
- tree_loaded  out  1  sticky: nodes+leaves complete
- query_loaded  out  1  sticky: queries complete
- cmd_err  out  1  sticky: illegal command seen

## Operation
- States: IDLE, NODES, LEAVES, QUERIES.
- IDLE: load_kdtree → NODES, clears tree_loaded and query_loaded. load_query → QUERIES if tree_loaded, clears query_loaded; else cmd_err=1, stay IDLE. Both asserted together: load_kdtree wins.
- Any command while busy: ignored, cmd_err=1.
- in_ready = busy && in_valid; a word is accepted when in_ready=1. No words consumed in IDLE.
- NODES: 2 words per node (dim, median). After median of node NUM_NODES-1 → LEAVES.
- LEAVES: PATCH_SIZE data words then 1 index word per patch; slot increments 0..LEAF_SIZE-1 then leaf increments. After last word of leaf NUM_LEAVES-1 slot LEAF_SIZE-1 → tree_loaded=1, → QUERIES.
- QUERIES: PATCH_SIZE words per query. After query NUM_QUERYS-1 → query_loaded=1, → IDLE.
- Element counter, slot counter and item counters reset to 0 on every state entry; no wrap beyond terminal counts.
- Idle cycles (in_valid=0) inside any phase stall counters with no effect.
- cmd_err cleared only by rst.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, shift registers 0.
- Command to state change: 1 cycle; first word can be accepted the cycle after command.
- Write strobes are registered: node_wen/leaf_wen/query_wen pulse exactly 1 cycle, the cycle after the completing word (median / index / 5th element) is accepted; addresses and data stable during the pulse.
- State transition occurs on the same edge as the completing word; busy falls on that edge for the final query; query_wen for the last query and query_loaded=1 appear together on the next cycle.
- Throughput: 1 word/cycle sustained, no bubbles between phases.
- rst mid-load: immediate abort, no further strobes, flags cleared.

## Test plan
- Full load, continuous in_valid: 126 node words, 3072 leaf words, 2470 query words → 63 node_wen, 512 leaf_wen, 494 query_wen; node 62 dim/median match words 124/125; tree_loaded high after leaf 63 slot 7; busy low after 5668 accepted words.
- Leaf packing: leaf 3 slot 5 words 1,2,3,4,5,300 → leaf_wdata elements {1..5} LSB-first, leaf_widx=300, leaf_waddr=3, leaf_slot=5.
- Random in_valid gaps (50%) → identical write sequence to continuous case; in_ready never high while in_valid=0.
- load_query before any tree load → cmd_err=1, busy stays 0; after full load, load_query + 2470 words → 494 query_wen, tree_loaded remains 1.
- load_kdtree during QUERIES → ignored, cmd_err=1, load completes normally.
- rst asserted after 1000 leaf words → all outputs 0 same cycle; subsequent load_kdtree restarts at node 0.
